// File: rtl/mul8_dot_accum.sv
`default_nettype none
// ============================================================================
// Module      : mul8_dot_accum
// Description : Dot-product accumulator around an external 8x8 multiplier.
//               Optional macro MUL8_DOT_SAT_EN clamps the sum instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mul8_dot_accum #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             op_vld_q, op_vld_d;
  logic             op_last_q, op_last_d;
  logic [7:0]       mul_a_q, mul_a_d;
  logic [7:0]       mul_b_q, mul_b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept_w;
  logic [ACC_W:0]   add_w;
  logic             carry_w;
  logic [ACC_W-1:0] acc_next_w;
  logic [CNT_W-1:0] cnt_next_w;
  logic             ovf_next_w;

  // Ready is gated by rst_n so it drops immediately when reset asserts.
  assign in_ready  = rst_n && (state_q == ST_ACC) && !(op_vld_q && op_last_q);
  assign accept_w  = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    add_w      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(mul_p);
    carry_w    = add_w[ACC_W];
`ifdef MUL8_DOT_SAT_EN
    acc_next_w = carry_w ? {ACC_W{1'b1}} : add_w[ACC_W-1:0];
`else
    acc_next_w = add_w[ACC_W-1:0];
`endif
    ovf_next_w = ovf_q | carry_w;
    cnt_next_w = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    op_vld_d  = 1'b0;
    op_last_d = op_last_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;

    if (accept_w) begin
      mul_a_d   = in_a;
      mul_b_d   = in_b;
      op_last_d = in_last;
      op_vld_d  = 1'b1;
    end

    case (state_q)
      ST_ACC: begin
        if (op_vld_q) begin
          if (op_last_q) begin
            // Final term: publish the result and start the next vector from zero.
            out_sum_d = acc_next_w;
            out_cnt_d = cnt_next_w;
            out_ovf_d = ovf_next_w;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ST_DONE;
          end else begin
            acc_d = acc_next_w;
            cnt_d = cnt_next_w;
            ovf_d = ovf_next_w;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      op_vld_q  <= 1'b0;
      op_last_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_vld_q  <= op_vld_d;
      op_last_q <= op_last_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul8_dot_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul8_dot_accum
// Description : Self-checking bench; three DUT configurations share one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul8_dot_accum;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_last, out_ready;
  logic [7:0] in_a, in_b;

  logic        rdy0, vld0, ovf0;
  logic [7:0]  ma0, mb0;
  logic [15:0] p0;
  logic [23:0] sum0;
  logic [7:0]  cnt0;

  logic        rdy1, vld1, ovf1;
  logic [7:0]  ma1, mb1;
  logic [15:0] p1;
  logic [15:0] sum1;
  logic [7:0]  cnt1;

  logic        rdy2, vld2, ovf2;
  logic [7:0]  ma2, mb2;
  logic [15:0] p2;
  logic [23:0] sum2;
  logic [1:0]  cnt2;

  assign p0 = 16'(ma0) * 16'(mb0);
  assign p1 = 16'(ma1) * 16'(mb1);
  assign p2 = 16'(ma2) * 16'(mb2);

  mul8_dot_accum #(.ACC_W(24), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma0), .mul_b(mb0),
    .mul_p(p0), .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0),
    .out_cnt(cnt0), .out_ovf(ovf0));

  mul8_dot_accum #(.ACC_W(16), .CNT_W(8)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma1), .mul_b(mb1),
    .mul_p(p1), .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1),
    .out_cnt(cnt1), .out_ovf(ovf1));

  mul8_dot_accum #(.ACC_W(24), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma2), .mul_b(mb2),
    .mul_p(p2), .out_valid(vld2), .out_ready(out_ready), .out_sum(sum2),
    .out_cnt(cnt2), .out_ovf(ovf2));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] va [16];
  logic [7:0] vb [16];

  // Reference: exact sum of products, then clamp or wrap to the result width.
  function automatic longint exp_sum(input longint tot, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
`ifdef MUL8_DOT_SAT_EN
    return (tot > lim) ? lim : tot;
`else
    return tot & lim;
`endif
  endfunction

  function automatic longint min_l(input longint x, input longint y);
    return (x < y) ? x : y;
  endfunction

  // Sends va/vb[0..n-1], holds the result for 'hold' cycles, then handshakes.
  task automatic run_vec(input int n, input int hold, input bit gaps, input bit strm);
    longint tot;
    longint e_s0, e_s1, e_s2, e_c0, e_c2;
    bit     e_o0, e_o1;
    int     budget;
    tot = 0;
    for (int i = 0; i < n; i++) tot += longint'(va[i]) * longint'(vb[i]);
    e_s0 = exp_sum(tot, 24); e_o0 = (tot > 64'hFFFFFF);
    e_s1 = exp_sum(tot, 16); e_o1 = (tot > 64'hFFFF);
    e_s2 = exp_sum(tot, 24);
    e_c0 = min_l(n, 255);    e_c2 = min_l(n, 3);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_last = (i == n - 1);
      budget = 0;
      while (!rdy0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      n_tests++;
      if (budget >= 20 || (strm && budget != 0)) begin
        n_fail++;
        $display("FAIL accept_wait: waited %0d cycles, required 0 (pair %0d)", budget, i);
      end
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (ma0 !== va[i] || mb0 !== vb[i]) begin
        n_fail++;
        $display("FAIL mul_operands: got %0d,%0d required %0d,%0d", ma0, mb0, va[i], vb[i]);
      end
      if (strm && i < n - 1) begin
        n_tests++;
        if (rdy0 !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_ready: in_ready=%b required 1 after pair %0d", rdy0, i);
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_tests++;
    if (vld0 !== 1'b0 || rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL last_in_flight: out_valid=%b in_ready=%b required 0,0", vld0, rdy0);
    end
    @(negedge clk);
    n_tests++;
    if ({vld0, vld1, vld2} !== 3'b111) begin
      n_fail++;
      $display("FAIL out_valid_latency: got %b required 111", {vld0, vld1, vld2});
    end
    n_tests++;
    if (sum0 !== 24'(e_s0) || cnt0 !== 8'(e_c0) || ovf0 !== e_o0) begin
      n_fail++;
      $display("FAIL result_acc24: sum=%0d cnt=%0d ovf=%b required %0d,%0d,%b",
               sum0, cnt0, ovf0, e_s0, e_c0, e_o0);
    end
    n_tests++;
    if (sum1 !== 16'(e_s1) || cnt1 !== 8'(e_c0) || ovf1 !== e_o1) begin
      n_fail++;
      $display("FAIL result_acc16: sum=%0d cnt=%0d ovf=%b required %0d,%0d,%b",
               sum1, cnt1, ovf1, e_s1, e_c0, e_o1);
    end
    n_tests++;
    if (sum2 !== 24'(e_s2) || cnt2 !== 2'(e_c2) || ovf2 !== e_o0) begin
      n_fail++;
      $display("FAIL result_cnt2: sum=%0d cnt=%0d ovf=%b required %0d,%0d,%b",
               sum2, cnt2, ovf2, e_s2, e_c2, e_o0);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_tests++;
      if (vld0 !== 1'b1 || rdy0 !== 1'b0 || sum0 !== 24'(e_s0) || cnt0 !== 8'(e_c0)) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b ready=%b sum=%0d cnt=%0d required 1,0,%0d,%0d",
                 vld0, rdy0, sum0, cnt0, e_s0, e_c0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (vld0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_hs: out_valid=%b in_ready=%b required 0,1", vld0, rdy0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (rdy0 !== 1'b0 || vld0 !== 1'b0 || sum0 !== 24'd0 || cnt0 !== 8'd0 || ma0 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b sum=%0d cnt=%0d mul_a=%0d required all 0",
               rdy0, vld0, sum0, cnt0, ma0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'($urandom_range(1, 255)); in_b = 8'($urandom_range(1, 255));
      in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rdy0 !== 1'b0 || vld0 !== 1'b0 || sum0 !== 24'd0 || ovf0 !== 1'b0 ||
        ma0 !== 8'd0 || mb0 !== 8'd0 || cnt0 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b valid=%b sum=%0d ovf=%b mul=%0d,%0d required all 0",
               rdy0, vld0, sum0, ovf0, ma0, mb0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rdy0 !== 1'b1 || vld0 !== 1'b0 || sum0 !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b sum=%0d required 1,0,0", rdy0, vld0, sum0);
    end
    va[0] = 8'd2; vb[0] = 8'd3; va[1] = 8'd4; vb[1] = 8'd5;
    run_vec(2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin va[i] = 8'd255; vb[i] = 8'd255; end
    run_vec(4, 0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    va[0] = 8'd10; vb[0] = 8'd10;
    run_vec(1, 5, 1'b0, 1'b1);
  endtask

  task automatic test_single();
    va[0] = 8'd0; vb[0] = 8'd77;
    run_vec(1, 0, 1'b0, 1'b1);
    va[0] = 8'd1; vb[0] = 8'd1;
    run_vec(1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    va[0] = 8'd255; vb[0] = 8'd255; va[1] = 8'd255; vb[1] = 8'd255;
    run_vec(2, 0, 1'b0, 1'b1);
    // Enough full-scale terms to cross the 16-bit range several times.
    for (int i = 0; i < 9; i++) begin va[i] = 8'd255; vb[i] = 8'd254; end
    run_vec(9, 2, 1'b0, 1'b1);
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 5; i++) begin va[i] = 8'd1; vb[i] = 8'd1; end
    run_vec(5, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int v = 0; v < 20; v++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        va[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
        vb[i] = 8'($urandom_range(0, 255));
      end
      run_vec(n, $urandom_range(0, 3), 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = 8'd0; in_b = 8'd0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_single();
    test_overflow();
    test_count_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
